// File: rtl/event_encoder16x4_if.sv
// Handshake bundle between the event encoder (master) and its consumer (slave).
interface event_encoder16x4_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 4
);
  logic [WIDTH-1:0] x;
  logic [IDX_W-1:0] y;
  logic             y_valid;
  logic             y_ready;
  logic             overflow;
  logic             busy;

  modport master (
    input  x,
    input  y_ready,
    output y,
    output y_valid,
    output overflow,
    output busy
  );

  modport slave (
    output x,
    output y_ready,
    input  y,
    input  y_valid,
    input  overflow,
    input  busy
  );
endinterface

// File: rtl/event_encoder16x4.sv
// Rising-edge event encoder: synchronises WIDTH lines, queues one event per line and
// emits 4-bit indices over valid/ready. Define ENC_ROUND_ROBIN_EN for rotating priority.
module event_encoder16x4 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  event_encoder16x4_if.master bus
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] x_prev_q, x_prev_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] take_mask;
  logic [IDX_W-1:0] sel_idx;
  logic             load;

`ifdef ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] rotated;
  int unsigned      wrap_idx;

  // Rotate pending so rr_ptr lands on bit 0, then take the lowest set bit.
  always_comb begin
    sel_idx  = '0;
    wrap_idx = 0;
    rotated  = (pending_q >> rr_ptr_q) | (pending_q << (WIDTH - int'(rr_ptr_q)));
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        wrap_idx = int'(rr_ptr_q) + i;
        if (wrap_idx >= WIDTH) wrap_idx = wrap_idx - WIDTH;
        sel_idx = IDX_W'(wrap_idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      rr_ptr_d = (sel_idx == IDX_W'(WIDTH - 1)) ? '0 : sel_idx + IDX_W'(1);
    end
  end
`else
  // Fixed priority: lowest pending index wins.
  always_comb begin
    sel_idx = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    s1_d       = bus.x;
    s2_d       = s1_q;
    x_prev_d   = s2_q;
    rise       = s2_q & ~x_prev_q;
    load       = (!y_valid_q || bus.y_ready) && (|pending_q);
    take_mask  = load ? (WIDTH'(1) << sel_idx) : '0;
    // A same-line take and rise keeps the bit set as a fresh event, not an overflow.
    pending_d  = (pending_q & ~take_mask) | rise;
    overflow_d = |(rise & pending_q & ~take_mask);
    y_d        = y_q;
    y_valid_d  = y_valid_q;
    if (load) begin
      y_d       = sel_idx;
      y_valid_d = 1'b1;
    end else if (y_valid_q && bus.y_ready) begin
      y_valid_d = 1'b0;
    end
    busy_d = (|pending_d) | y_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      x_prev_q   <= '0;
      pending_q  <= '0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      x_prev_q   <= x_prev_d;
      pending_q  <= pending_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
`ifdef ENC_ROUND_ROBIN_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign bus.y        = y_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_event_encoder16x4.sv
// Directed self-checking bench for event_encoder16x4: reset, latency, ordering,
// backpressure/overflow, same-cycle take+rise and mid-stream reset.
module tb_event_encoder16x4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [3:0]  t3_order [3];
  logic [15:0] t4_pat   [10];

  event_encoder16x4_if #(.WIDTH(16), .IDX_W(4)) bus ();

  event_encoder16x4 #(.WIDTH(16), .IDX_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [3:0] yy,
                         input logic o, input logic b);
    chk({tag, ".y_valid"},  32'(bus.y_valid),  32'(v));
    chk({tag, ".y"},        32'(bus.y),        32'(yy));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(o));
    chk({tag, ".busy"},     32'(bus.busy),     32'(b));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
`ifdef ENC_ROUND_ROBIN_EN
    t3_order[0] = 4'd9;  t3_order[1] = 4'd14; t3_order[2] = 4'd2;
`else
    t3_order[0] = 4'd2;  t3_order[1] = 4'd9;  t3_order[2] = 4'd14;
`endif
    t4_pat[0] = 16'h0000; t4_pat[1] = 16'h0008; t4_pat[2] = 16'h0000;
    for (int k = 3; k < 10; k++) t4_pat[k] = 16'h0008;

    // T1: reset with all lines high
    rst_n       = 1'b0;
    bus.x       = 16'hFFFF;
    bus.y_ready = 1'b1;
    repeat (2) begin
      step();
      chk_all("t1_reset", 1'b0, 4'd0, 1'b0, 1'b0);
    end
    bus.x = 16'h0000;
    rst_n = 1'b1;
    repeat (4) step();
    chk_all("t1_idle", 1'b0, 4'd0, 1'b0, 1'b0);

    // T2: single rise on line 5, three-cycle latency, one event
    bus.x = 16'h0020;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t2_lat.y_valid", 32'(bus.y_valid), 32'(0));
    end
    step();
    chk_all("t2_event", 1'b1, 4'd5, 1'b0, 1'b1);
    step();
    chk_all("t2_done", 1'b0, 4'd5, 1'b0, 1'b0);
    repeat (4) step();
    chk_all("t2_stuck_high", 1'b0, 4'd5, 1'b0, 1'b0);
    bus.x = 16'h0000;
    repeat (4) step();
    chk_all("t2_fall", 1'b0, 4'd5, 1'b0, 1'b0);

    // T3: burst on lines 2, 9, 14
    bus.x = 16'h4204;
    repeat (3) step();
    chk_all("t3_pend", 1'b0, 4'd5, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all("t3_burst", 1'b1, t3_order[k], 1'b0, 1'b1);
    end
    step();
    chk_all("t3_done", 1'b0, t3_order[2], 1'b0, 1'b0);
    bus.x = 16'h0000;
    repeat (4) step();

    // T4: backpressure on y=3 while line 3 re-rises twice
    bus.y_ready = 1'b0;
    bus.x       = 16'h0008;
    repeat (4) step();
    chk_all("t4_first", 1'b1, 4'd3, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      bus.x = t4_pat[k];
      step();
      chk_all("t4_hold", 1'b1, 4'd3, (k == 5) ? 1'b1 : 1'b0, 1'b1);
    end
    bus.y_ready = 1'b1;
    step();
    chk_all("t4_extra", 1'b1, 4'd3, 1'b0, 1'b1);
    step();
    chk_all("t4_done", 1'b0, 4'd3, 1'b0, 1'b0);
    bus.x = 16'h0000;
    repeat (4) step();

    // T5: line 7 re-rises in the cycle its event is loaded
    bus.y_ready = 1'b0;
    bus.x       = 16'h00A0;
    repeat (4) step();
    chk_all("t5_first", 1'b1, 4'd5, 1'b0, 1'b1);
    bus.x = 16'h0020;
    step();
    chk_all("t5_b1", 1'b1, 4'd5, 1'b0, 1'b1);
    bus.x = 16'h00A0;
    step();
    chk_all("t5_b2", 1'b1, 4'd5, 1'b0, 1'b1);
    step();
    chk_all("t5_b3", 1'b1, 4'd5, 1'b0, 1'b1);
    bus.y_ready = 1'b1;
    step();
    chk_all("t5_take", 1'b1, 4'd7, 1'b0, 1'b1);
    step();
    chk_all("t5_again", 1'b1, 4'd7, 1'b0, 1'b1);
    step();
    chk_all("t5_done", 1'b0, 4'd7, 1'b0, 1'b0);
    bus.x = 16'h0000;
    repeat (4) step();

    // T6: reset with four events outstanding
    bus.y_ready = 1'b0;
    bus.x       = 16'h000F;
    repeat (4) step();
    chk_all("t6_loaded", 1'b1, 4'd0, 1'b0, 1'b1);
    rst_n = 1'b0;
    bus.x = 16'h0000;
    step();
    chk_all("t6_reset", 1'b0, 4'd0, 1'b0, 1'b0);
    rst_n       = 1'b1;
    bus.y_ready = 1'b1;
    repeat (6) begin
      step();
      chk_all("t6_after", 1'b0, 4'd0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
